// File: rtl/sync_edge_filter.sv
// Multi-channel input conditioner: synchroniser chain, stability filter,
// mode-selected edge detector and saturating edge counter per channel.
module sync_edge_filter #(
    parameter int   CHANNELS      = 4,
    parameter int   SYNC_STAGES   = 3,
    parameter int   FILTER_CYCLES = 4,
    parameter int   FILTER_W      = 8,
    parameter int   EDGE_CNT_W    = 16,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CHANNELS-1:0]              async_in,
    input  logic [2*CHANNELS-1:0]            edge_mode,
    input  logic [CHANNELS-1:0]              cnt_clear,
    output logic [CHANNELS-1:0]              level_out,
    output logic [CHANNELS-1:0]              rise_pulse,
    output logic [CHANNELS-1:0]              fall_pulse,
    output logic [CHANNELS-1:0]              edge_pulse,
    output logic [CHANNELS*EDGE_CNT_W-1:0]   edge_count,
    output logic [CHANNELS-1:0]              overflow
);

    // FILTER_CYCLES of 0 and 1 both mean a single-cycle qualification
    localparam int                    F_EFF   = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
    localparam logic [FILTER_W-1:0]   F_LAST  = FILTER_W'(F_EFF - 1);
    localparam logic [EDGE_CNT_W-1:0] CNT_MAX = {EDGE_CNT_W{1'b1}};
    localparam logic [CHANNELS-1:0]   LVL_RST = {CHANNELS{RESET_VAL}};

    logic [CHANNELS-1:0]   sync_r [SYNC_STAGES];
    logic [CHANNELS-1:0]   sync_q_s;
    logic [FILTER_W-1:0]   filt_cnt_r     [CHANNELS];
    logic [FILTER_W-1:0]   filt_cnt_nxt_s [CHANNELS];
    logic [CHANNELS-1:0]   level_r;
    logic [CHANNELS-1:0]   level_nxt_s;
    logic [CHANNELS-1:0]   level_d_r;
    logic [CHANNELS-1:0]   rise_s;
    logic [CHANNELS-1:0]   fall_s;
    logic [CHANNELS-1:0]   edge_sel_s;
    logic [CHANNELS-1:0]   rise_r;
    logic [CHANNELS-1:0]   fall_r;
    logic [CHANNELS-1:0]   edge_r;
    logic [EDGE_CNT_W-1:0] cnt_r     [CHANNELS];
    logic [EDGE_CNT_W-1:0] cnt_nxt_s [CHANNELS];
    logic [CHANNELS-1:0]   ovf_r;
    logic [CHANNELS-1:0]   ovf_nxt_s;

    assign sync_q_s = sync_r[SYNC_STAGES-1];

    // Synchroniser shift chains, no logic between stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= LVL_RST;
            end
        end else begin
            sync_r[0] <= async_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // Stability filter: level follows sync_q only after F consecutive differing cycles
    always_comb begin
        level_nxt_s = level_r;
        for (int c = 0; c < CHANNELS; c++) begin
            filt_cnt_nxt_s[c] = {FILTER_W{1'b0}};
            if (sync_q_s[c] == level_r[c]) begin
                filt_cnt_nxt_s[c] = {FILTER_W{1'b0}};
            end else if (filt_cnt_r[c] == F_LAST) begin
                level_nxt_s[c]    = sync_q_s[c];
                filt_cnt_nxt_s[c] = {FILTER_W{1'b0}};
            end else begin
                filt_cnt_nxt_s[c] = filt_cnt_r[c] + FILTER_W'(1);
            end
        end
    end

    // Edge qualification against the mode sampled on the detecting edge
    always_comb begin
        rise_s     = level_r & ~level_d_r;
        fall_s     = ~level_r & level_d_r;
        edge_sel_s = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            case (edge_mode[2*c +: 2])
                2'b00:   edge_sel_s[c] = 1'b0;
                2'b01:   edge_sel_s[c] = rise_s[c];
                2'b10:   edge_sel_s[c] = fall_s[c];
                2'b11:   edge_sel_s[c] = rise_s[c] | fall_s[c];
                default: edge_sel_s[c] = 1'b0;
            endcase
        end
    end

    // Saturating counter; a clear overrides a coincident increment
    always_comb begin
        ovf_nxt_s = ovf_r;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_nxt_s[c] = cnt_r[c];
            if (cnt_clear[c]) begin
                cnt_nxt_s[c] = {EDGE_CNT_W{1'b0}};
                ovf_nxt_s[c] = 1'b0;
            end else if (edge_r[c]) begin
                if (cnt_r[c] == CNT_MAX) begin
                    ovf_nxt_s[c] = 1'b1;
                end else begin
                    cnt_nxt_s[c] = cnt_r[c] + EDGE_CNT_W'(1);
                end
            end else begin
                cnt_nxt_s[c] = cnt_r[c];
            end
        end
    end

    // Filter, level, pulse and counter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r   <= LVL_RST;
            level_d_r <= LVL_RST;
            rise_r    <= {CHANNELS{1'b0}};
            fall_r    <= {CHANNELS{1'b0}};
            edge_r    <= {CHANNELS{1'b0}};
            ovf_r     <= {CHANNELS{1'b0}};
            for (int c = 0; c < CHANNELS; c++) begin
                filt_cnt_r[c] <= {FILTER_W{1'b0}};
                cnt_r[c]      <= {EDGE_CNT_W{1'b0}};
            end
        end else begin
            level_r   <= level_nxt_s;
            level_d_r <= level_r;
            rise_r    <= rise_s;
            fall_r    <= fall_s;
            edge_r    <= edge_sel_s;
            ovf_r     <= ovf_nxt_s;
            for (int c = 0; c < CHANNELS; c++) begin
                filt_cnt_r[c] <= filt_cnt_nxt_s[c];
                cnt_r[c]      <= cnt_nxt_s[c];
            end
        end
    end

    assign level_out  = level_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign edge_pulse = edge_r;
    assign overflow   = ovf_r;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt_out
        assign edge_count[g*EDGE_CNT_W +: EDGE_CNT_W] = cnt_r[g];
    end

endmodule
